// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds
// and sticky overflow/underflow error flags.
module sync_fifo_ctl #(
    parameter int DW     = 4,
    parameter int AW     = 4,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wen,
    input  logic [DW-1:0] wdata,
    input  logic          ren,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic          aempty,
    output logic [AW:0]   count,
    input  logic          clr_err,
    output logic          ovf,
    output logic          udf
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wacc, racc;

    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign afull  = (count_q >= AF_C);
    assign aempty = (count_q <= AE_C);
    assign count  = count_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ovf    = ovf_q;
    assign udf    = udf_q;

    always_comb begin
        wacc     = wen & ~full;
        racc     = ren & ~empty;
        wptr_d   = wacc ? wptr_q + ONE_C : wptr_q;
        rptr_d   = racc ? rptr_q + ONE_C : rptr_q;
        count_d  = count_q;
        unique case ({wacc, racc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        // Non-empty read never aliases the write slot, so old mem is correct
        rdata_d  = racc ? mem_q[rptr_q[AW-1:0]] : rdata_q;
        rvalid_d = racc;
        ovf_d    = (wen & full) | (ovf_q & ~clr_err);
        udf_d    = (ren & empty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk) begin
        if (wacc) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed bench for sync_fifo_ctl with a queue-based reference model
// that doubles as the read-data scoreboard.
module tb_sync_fifo_ctl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wen = 1'b0;
    logic [3:0] wdata = '0;
    logic       ren = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] rdata;
    logic       rvalid, full, empty, afull, aempty, ovf, udf;
    logic [4:0] count;

    int vectors = 0;
    int errs = 0;

    logic [3:0] q[$];
    logic [3:0] exp_rdata;
    logic       exp_rvalid, exp_ovf, exp_udf;

    sync_fifo_ctl #(.DW(4), .AW(4), .AF_LVL(14), .AE_LVL(2)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .afull(afull), .aempty(aempty), .count(count), .clr_err(clr_err),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_rdata  = '0;
        exp_rvalid = 1'b0;
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 8'(count), 8'(n));
        chk({tag, ".full"}, 8'(full), 8'(n == 16));
        chk({tag, ".empty"}, 8'(empty), 8'(n == 0));
        chk({tag, ".afull"}, 8'(afull), 8'(n >= 14));
        chk({tag, ".aempty"}, 8'(aempty), 8'(n <= 2));
        chk({tag, ".ovf"}, 8'(ovf), 8'(exp_ovf));
        chk({tag, ".udf"}, 8'(udf), 8'(exp_udf));
        chk({tag, ".rvalid"}, 8'(rvalid), 8'(exp_rvalid));
        chk({tag, ".rdata"}, 8'(rdata), 8'(exp_rdata));
    endtask

    // One clock: drive, predict from pre-edge state, then compare
    task automatic cyc(input string tag, input logic w, input logic [3:0] wd,
                       input logic r, input logic c);
        logic mfull, mempty;
        mfull  = (q.size() == 16);
        mempty = (q.size() == 0);
        wen = w; wdata = wd; ren = r; clr_err = c;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr_err = 1'b0;
        exp_rvalid = r & ~mempty;
        if (exp_rvalid) exp_rdata = q.pop_front();
        if (w & ~mfull) q.push_back(wd);
        exp_ovf = (w & mfull) | (exp_ovf & ~c);
        exp_udf = (r & mempty) | (exp_udf & ~c);
        check_all(tag);
    endtask

    initial begin
        model_reset();
        #1;
        check_all("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) cyc("fill", 1'b1, 4'(i), 1'b0, 1'b0);
        cyc("wr_full", 1'b1, 4'h5, 1'b0, 1'b0);
        cyc("clr_ovf", 1'b0, 4'h0, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) cyc("drain", 1'b0, 4'h0, 1'b1, 1'b0);
        cyc("rd_empty", 1'b0, 4'h0, 1'b1, 1'b0);
        cyc("clr_udf", 1'b0, 4'h0, 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) cyc("to8", 1'b1, 4'(i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++)
            cyc("rw8", 1'b1, 4'(i + 8), 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) cyc("to16", 1'b1, 4'(3 * i), 1'b0, 1'b0);
        cyc("rw_full", 1'b1, 4'hA, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) cyc("drain2", 1'b0, 4'h0, 1'b1, 1'b0);
        cyc("rw_empty", 1'b1, 4'h9, 1'b1, 1'b0);
        cyc("rd_one", 1'b0, 4'h0, 1'b1, 1'b1);

        for (int i = 0; i < 16; i++) cyc("fill2", 1'b1, 4'(15 - i), 1'b0, 1'b0);
        cyc("ovf_set", 1'b1, 4'h1, 1'b0, 1'b0);
        cyc("ovf_clr_set", 1'b1, 4'h2, 1'b0, 1'b1);
        cyc("ovf_clr", 1'b0, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) cyc("to5", 1'b0, 4'h0, 1'b1, 1'b0);

        wen = 1'b1; wdata = 4'hC;
        #2;
        rst_n = 1'b0;
        #1;
        wen = 1'b0;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("post_rst_rd", 1'b0, 4'h0, 1'b1, 1'b0);
        cyc("post_rst_idle", 1'b0, 4'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO: buffer storage with read/write pointer management, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the same-clock counterpart of the team's dual-clock FIFO RAM. It generalises data width and depth, and adds flow-control status and error detection, which the RAM-only block lacks. It is used wherever producer and consumer share one clock domain.

## Interface
Parameters:
- DW, 4, data width in bits (≥1)
- AW, 4, address width; DEPTH = 2**AW entries (AW ≥ 1)
- AF_LVL, 14, almost-full threshold; legal range 1..DEPTH
- AE_LVL, 2, almost-empty threshold; legal range 0..DEPTH-1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk externally
- wen  in  1  write request
- wdata  in  DW  write data
- ren  in  1  read request
- rdata  out  DW  registered read data
- rvalid  out  1  rdata updated this cycle (one-cycle pulse per accepted read)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- afull  out  1  count ≥ AF_LVL
- aempty  out  1  count ≤ AE_LVL
- count  out  AW+1  current occupancy, 0..DEPTH
- clr_err  in  1  clears ovf/udf
- ovf  out  1  sticky: write attempted while full
- udf  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH × DW array. It is not reset.
- Pointers: wptr and rptr are AW+1 bits binary. The low AW bits address memory, and the pointers wrap naturally modulo 2·DEPTH.
- Write accepted (wacc) = wen & ~full. On wacc: mem[wptr] ← wdata and wptr increments.
- Read accepted (racc) = ren & ~empty. On racc: rdata ← mem[rptr], rvalid ← 1 next cycle, and rptr increments. Otherwise rvalid ← 0 and rdata holds its value.
- Accept decisions use the flags registered at the start of the cycle:
  - Full with wen & ren: the read is accepted, the write is rejected and ovf is set.
  - Empty with wen & ren: the write is accepted, the read is rejected and udf is set. The written word is not bypassed to rdata.
  - Neither full nor empty with wen & ren: both are accepted and count is unchanged.
- count next = count + wacc − racc. Width AW+1, never exceeds DEPTH, never below 0.
- Status flags are combinational decodes of registered count (full, empty, afull, aempty) and change only at clock edges.
- ovf ← 1 on wen & full; udf ← 1 on ren & empty. Both hold until clr_err is sampled high. If a new error and clr_err occur in the same cycle, set wins.
- Rejected requests do not modify the pointers, count, memory or rdata.
- Reset values: wptr = rptr = 0, count = 0, empty = 1, aempty = 1, full = 0, afull = 0, rvalid = 0, rdata = 0, ovf = 0, udf = 0.
- Reset mid-operation discards all contents immediately (asynchronous). After release the FIFO is empty, and stale memory is never presented because empty blocks reads.

## Timing
- Write-to-read latency: a word written at edge N is readable (empty = 0) after edge N. With ren asserted in cycle N+1, it appears on rdata with rvalid at edge N+2.
- Read latency: 1 cycle from accepted ren to rdata/rvalid.
- Flag latency: full, empty, afull, aempty and count reflect all accepted operations from the previous edge. There is no look-ahead.
- Sustained throughput: one write and one read per cycle when neither full nor empty.
- ovf/udf assert 1 cycle after the offending request.

## Test plan
- Reset, then 16 writes of 0x0..0xF with DW=4, AW=4 → full = 1 and afull = 1 after the 16th edge (afull = 1 from count 14); count = 16; ovf = 0.
- Write 0x5 when full → mem unchanged, count stays 16, ovf = 1 next cycle. Then clr_err pulse → ovf = 0.
- Drain the full FIFO with 16 consecutive reads → rdata sequence 0x0..0xF, each with an rvalid pulse. empty = 1 after the last read; aempty = 1 from count 2. One extra ren → udf = 1, rvalid stays 0.
- Simultaneous wen & ren at count = 8 for 40 cycles with an incrementing pattern → count stays 8, data order preserved across pointer wrap (more than 2·DEPTH increments). Same test at full (write rejected, ovf = 1) and at empty (read rejected, udf = 1, count → 1).
- Assert rst_n = 0 mid-burst at count = 5 → all outputs take reset values immediately without a clock. After release, ren yields udf = 1 and no rvalid.
- Same-cycle clr_err and overflow while ovf = 1 → ovf remains 1.
